imem_loader: RTL

//  Writer side of the instruction-memory port: streams a program image from a byte source
//  (UART receiver, valid/ready) into instruction memory. Holds the core in reset while loading.

---
 rtl/loader_pkg.sv | 18 +
 rtl/word_packer.sv | 36 +++
 rtl/imem_loader.sv | 138 +++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// Shared types for the instruction-memory loader.
// Holds the loader FSM state encoding and frame-format constants.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        BYTE,
        WRITE,
        DONE,
        ERROR
    } loader_state_t;

    localparam int LEN_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/word_packer.sv
// Assembles 4 accepted bytes into a 32-bit little-endian word.
// Ports: i_clk, i_rst_n, i_clear, i_valid, i_byte in; o_word, o_full out.
module word_packer
    import loader_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_clear,
    input  logic        i_valid,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_full
);

    logic [1:0]  r_cnt;
    logic [31:0] r_word;

    // Bytes enter at the top and shift down, so the first byte
    // ends up in [7:0] once the fourth one arrives.
    assign o_word = {i_byte, r_word[31:8]};
    assign o_full = i_valid && (r_cnt == 2'(BYTES_PER_WORD - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt  <= '0;
            r_word <= '0;
        end else if (i_clear) begin
            r_cnt  <= '0;
            r_word <= '0;
        end else if (i_valid) begin
            r_word <= o_word;
            r_cnt  <= r_cnt + 2'd1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed program image into instruction memory
// and holds the core in reset until the last word is written.
// Ports: clk, reset_n, start, rx_data/rx_valid in; rx_ready,
//   imem_we/addr/wdata, core_reset_n, busy, done, error out.
module imem_loader
    import loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter bit AUTO_START = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  core_reset_n,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam loader_state_t RST_STATE = AUTO_START ? LEN_LO : IDLE;
    localparam int            LEN_W     = LEN_BYTES * 8;

    loader_state_t         r_state;
    loader_state_t         w_next;
    logic [LEN_W-1:0]      r_len;
    logic [ADDR_WIDTH:0]   r_wcnt;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_wdata;
    logic                  r_core_rst_n;

    logic                  w_acc;
    logic                  w_clear;
    logic [LEN_W-1:0]      w_len_n;
    logic                  w_too_big;
    logic                  w_last;
    logic [31:0]           w_word;
    logic                  w_full;

    assign rx_ready = (r_state == LEN_LO) || (r_state == LEN_HI) ||
                      (r_state == BYTE);
    assign w_acc    = rx_valid && rx_ready;

    // Full length as it will be once the high byte lands.
    assign w_len_n   = {rx_data, r_len[7:0]};
    assign w_too_big = 32'(w_len_n) > (32'd1 << ADDR_WIDTH);
    assign w_last    = (32'(r_wcnt) + 32'd1) == 32'(r_len);

    word_packer u_packer (
        .i_clk   (clk),
        .i_rst_n (reset_n),
        .i_clear (w_clear),
        .i_valid (w_acc && (r_state == BYTE)),
        .i_byte  (rx_data),
        .o_word  (w_word),
        .o_full  (w_full)
    );

    always_comb begin
        w_next  = r_state;
        w_clear = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_next  = LEN_LO;
                    w_clear = 1'b1;
                end
            end
            LEN_LO: begin
                if (w_acc) w_next = LEN_HI;
            end
            LEN_HI: begin
                if (w_acc) begin
                    if (w_len_n == '0)  w_next = DONE;
                    else if (w_too_big) w_next = ERROR;
                    else                w_next = BYTE;
                end
            end
            BYTE: begin
                if (w_full) w_next = WRITE;
            end
            WRITE: begin
                w_next = w_last ? DONE : BYTE;
            end
            DONE, ERROR: begin
                if (start) begin
                    w_next  = LEN_LO;
                    w_clear = 1'b1;
                end
            end
            default: w_next = RST_STATE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= RST_STATE;
            r_len        <= '0;
            r_wcnt       <= '0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_core_rst_n <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_core_rst_n <= (w_next == DONE);
            r_we         <= (w_next == WRITE);
            if (w_clear) begin
                r_len  <= '0;
                r_wcnt <= '0;
            end
            if ((r_state == LEN_LO) && w_acc) r_len[7:0]  <= rx_data;
            if ((r_state == LEN_HI) && w_acc) r_len[15:8] <= rx_data;
            // Capture the completed word so addr/data hold through WRITE.
            if ((r_state == BYTE) && w_full) begin
                r_addr  <= r_wcnt[ADDR_WIDTH-1:0];
                r_wdata <= w_word;
            end
            if (r_state == WRITE) r_wcnt <= r_wcnt + 1'b1;
        end
    end

    assign imem_we      = r_we;
    assign imem_addr    = r_addr;
    assign imem_wdata   = r_wdata;
    assign core_reset_n = r_core_rst_n;
    assign busy         = (r_state == LEN_LO) || (r_state == LEN_HI) ||
                          (r_state == BYTE)   || (r_state == WRITE);
    assign done         = (r_state == DONE);
    assign error        = (r_state == ERROR);

endmodule
